fetch_pc_unit: RTL

- Fetch-stage PC generator and instruction-fetch sequencer on the receiving end of the execute-stage jump/redirect and decode-stall interface.
- Keeps the architectural fetch PC and issues single-outstanding requests to instruction memory.
- Holds each fetched instruction in an output buffer until the D pipeline register accepts it.
- Applies execute redirects and discards in-flight responses made stale by a redirect.

---
 rtl/fetch_pc_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: single-outstanding instruction fetch with a one-entry
// output buffer toward decode, execute redirects and stale-response discard.
module fetch_pc_unit #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INST_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              execute_i_need_jump,
    input  logic [ADDR_W-1:0] execute_i_jump_pc,
    input  logic              regD_stall,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              fetch_o_valid,
    output logic [ADDR_W-1:0] fetch_o_pc,
    output logic [INST_W-1:0] fetch_o_inst
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
    logic [INST_W-1:0] buf_inst_q, buf_inst_d;
    logic [ADDR_W-1:0] jump_target;

    assign jump_target = {execute_i_jump_pc[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_d      = drop_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_inst_d  = buf_inst_q;

        case (state_q)
            StReq: begin
                if (execute_i_need_jump) begin
                    pc_d = jump_target;
                end else if (imem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    if (drop_q || execute_i_need_jump) begin
                        // Response belongs to a fetch made stale by a redirect
                        drop_d  = 1'b0;
                        state_d = StReq;
                        if (execute_i_need_jump) begin
                            pc_d = jump_target;
                        end
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_pc_d    = pc_q;
                        buf_inst_d  = imem_resp_data;
                        pc_d        = pc_q + ADDR_W'(4);
                        state_d     = StHold;
                    end
                end else if (execute_i_need_jump) begin
                    pc_d   = jump_target;
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (execute_i_need_jump) begin
                    buf_valid_d = 1'b0;
                    pc_d        = jump_target;
                    state_d     = StReq;
                end else if (!regD_stall) begin
                    buf_valid_d = 1'b0;
                    state_d     = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StReq;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_inst_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_inst_q  <= buf_inst_d;
        end
    end

    assign imem_req_valid = (state_q == StReq) && !execute_i_need_jump;
    assign imem_req_addr  = pc_q;
    assign fetch_o_valid  = buf_valid_q;
    assign fetch_o_pc     = buf_pc_q;
    assign fetch_o_inst   = buf_inst_q;

endmodule
